store_merge_unit: RTL

//  Store-side counterpart of the load extraction path. Handles word, byte and halfword stores.

---
 rtl/store_merge_unit_if.sv | 28 ++
 rtl/store_merge_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/store_merge_unit_if.sv
// Store request and data-memory signal bundle for store_merge_unit.
// slave is the unit's own view; master is the view of the pipeline/memory side.
interface store_merge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  Req;
    logic [1:0]            MemWrite;
    logic [ADDR_WIDTH-1:0] Address;
    logic [31:0]           WriteData;
    logic                  Busy;
    logic                  Done;
    logic                  AlignErr;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic                  MemRdEn;
    logic [31:0]           MemRdData;
    logic                  MemWrEn;
    logic [31:0]           MemWrData;

    modport slave (
        input  Req, MemWrite, Address, WriteData, MemRdData,
        output Busy, Done, AlignErr, MemAddr, MemRdEn, MemWrEn, MemWrData
    );

    modport master (
        output Req, MemWrite, Address, WriteData, MemRdData,
        input  Busy, Done, AlignErr, MemAddr, MemRdEn, MemWrEn, MemWrData
    );
endinterface

// File: rtl/store_merge_unit.sv
// Word/byte/halfword store unit for a big-endian word memory without byte enables.
// Define MISALIGN_TRAP_EN to reject misaligned sh/sw with an AlignErr pulse.
//
// state   | meaning
// S_IDLE  | waiting for a store request
// S_RD    | read strobe for the read-modify-write word
// S_WAIT  | counting down remaining read latency
// S_MERGE | read data valid; merge the new lane into it
// S_WR    | write strobe and Done
module store_merge_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input logic             Clk_i,
    input logic             Reset_n_i,
    store_merge_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_MERGE,
        S_WR
    } state_t;

    localparam logic [1:0] WAIT_LOAD = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [31:0]           wrdata_q, wrdata_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  misalign;
    logic [31:0]           merged;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = ((bus.MemWrite == 2'd3) && bus.Address[0]) ||
                   ((bus.MemWrite == 2'd1) && (bus.Address[1:0] != 2'b00));
    end
`else
    always_comb begin
        misalign = 1'b0;
    end
`endif

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        merged = bus.MemRdData;
        if (op_q == 2'd2) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = wdata_q;
        end else begin
            merged[31:16] = wdata_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wrdata_d = wrdata_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Req && (bus.MemWrite != 2'd0)) begin
                    op_d    = bus.MemWrite;
                    addr_d  = bus.Address;
                    wdata_d = bus.WriteData[15:0];
                    if (misalign) begin
                        err_d = 1'b1;
                    end else if (bus.MemWrite == 2'd1) begin
                        wrdata_d = bus.WriteData;
                        state_d  = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                cnt_d   = WAIT_LOAD;
                state_d = (RD_LATENCY > 1) ? S_WAIT : S_MERGE;
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_MERGE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_MERGE: begin
                wrdata_d = merged;
                state_d  = S_WR;
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            state_q  <= S_IDLE;
            op_q     <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= 16'd0;
            wrdata_q <= 32'd0;
            cnt_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wrdata_q <= wrdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.MemRdEn   = (state_q == S_RD);
    assign bus.MemWrEn   = (state_q == S_WR);
    assign bus.Done      = (state_q == S_WR) || err_q;
    assign bus.MemAddr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.MemWrData = wrdata_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.AlignErr  = err_q;
`else
    assign bus.AlignErr  = 1'b0;
`endif
endmodule
